// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter for a shared decoder path.
// The grant is one-hot and registered, with a binary owner index and hold-limit preemption.
module decoder_rr_arbiter #(
  parameter int N        = 4,
  parameter int IDX_W    = $clog2(N),
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             preempt
);

  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_LIM =
    HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [IDX_W:0] NN = (IDX_W + 1)'(N);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             pre_q, pre_d;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_ok;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] nxt_ptr;
  logic             others;
  logic             at_lim;

  // Scan from farthest to nearest so the entry closest to ptr wins
  always_comb begin
    pick_idx = '0;
    pick_ok  = 1'b0;
    sum      = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_q} + (IDX_W + 1)'(k);
      if (sum >= NN) sum = sum - NN;
      if (req[sum[IDX_W-1:0]]) begin
        pick_ok  = 1'b1;
        pick_idx = sum[IDX_W-1:0];
      end
    end
  end

  assign nxt_ptr = (idx_q == LAST) ? '0 : idx_q + 1'b1;
  assign others  = |(req & ~grant_q);
  // >= keeps a long lone holder preemptible once a rival shows up
  assign at_lim  = (MAX_HOLD > 0) && (hold_q >= HOLD_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      pre_q   <= pre_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    pre_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        if (pick_ok) begin
          state_d = BUSY;
          grant_d = {{(N-1){1'b0}}, 1'b1} << pick_idx;
          idx_d   = pick_idx;
          hold_d  = '0;
        end
      end
      BUSY: begin
        if (!req[idx_q]) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = nxt_ptr;
        end else if (at_lim && others) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = nxt_ptr;
          pre_d   = 1'b1;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant       = grant_q;
    grant_idx   = idx_q;
    grant_valid = |grant_q;
    preempt     = pre_q;
  end

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Bench for decoder_rr_arbiter: directed scenarios plus random traffic
// checked against an owner/tenure reference model.
module tb_decoder_rr_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int MH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_idx;
  logic          grant_valid;
  logic          preempt;

  int checks = 0;
  int errors = 0;

  int m_owner = -1;
  int m_ptr   = 0;
  int m_ten   = 0;
  bit m_pre   = 1'b0;

  decoder_rr_arbiter #(.N(N), .IDX_W(IW), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .req(req),
    .grant(grant), .grant_idx(grant_idx),
    .grant_valid(grant_valid), .preempt(preempt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic model(input logic [N-1:0] r, input logic rs);
    int o;
    if (rs) begin
      m_owner = -1; m_ptr = 0; m_ten = 0; m_pre = 0;
    end else if (m_owner < 0) begin
      m_pre = 0;
      for (int k = 0; k < N; k++) begin
        o = (m_ptr + k) % N;
        if (m_owner < 0 && r[o]) m_owner = o;
      end
      if (m_owner >= 0) m_ten = 1;
    end else if (!r[m_owner]) begin
      m_ptr = (m_owner + 1) % N; m_owner = -1; m_pre = 0;
    end else if (MH > 0 && m_ten >= MH &&
                 (int'(r) & ~(1 << m_owner)) != 0) begin
      m_ptr = (m_owner + 1) % N; m_owner = -1; m_pre = 1;
    end else begin
      m_ten++; m_pre = 0;
    end
  endtask

  task automatic compare();
    int eg;
    eg = (m_owner >= 0) ? (1 << m_owner) : 0;
    chk("grant", int'(grant), eg);
    chk("valid", int'(grant_valid), int'(m_owner >= 0));
    chk("preempt", int'(preempt), int'(m_pre));
    chk("onehot0", int'($onehot0(grant)), 1);
    if (grant_valid) begin
      chk("idx", int'(grant_idx), m_owner);
      chk("idx_vs_grant", int'(grant[grant_idx]), 1);
    end
  endtask

  task automatic step(input logic [N-1:0] r, input logic rs);
    req = r; rst = rs;
    @(posedge clk);
    model(r, rs);
    #1 compare();
  endtask

  initial begin
    logic [N-1:0] rv;

    // Reset with all requests asserted, then first grant to 0
    repeat (3) begin
      step(4'b1111, 1'b1);
      chk("rst_grant", int'(grant), 0);
      chk("rst_valid", int'(grant_valid), 0);
    end
    step(4'b1111, 1'b0);
    chk("rst_first", int'(grant), 4'b0001);

    // Rotation under full load
    step(4'b1111, 1'b1);
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < MH; c++) begin
        step(4'b1111, 1'b0);
        chk("rot_grant", int'(grant), 1 << (r % 4));
      end
      step(4'b1111, 1'b0);
      chk("rot_gap", int'(grant), 0);
      chk("rot_pre", int'(preempt), 1);
    end

    // Lone holder is never preempted
    step(4'b0000, 1'b1);
    for (int c = 0; c < 20; c++) begin
      step(4'b0100, 1'b0);
      chk("lone_grant", int'(grant), 4'b0100);
      chk("lone_pre", int'(preempt), 0);
    end

    // Release from owner 1, then wrap from owner 3
    step(4'b0000, 1'b1);
    step(4'b0010, 1'b0);
    chk("rel_own1", int'(grant), 4'b0010);
    step(4'b1011, 1'b0);
    step(4'b1011, 1'b0);
    step(4'b1001, 1'b0);
    chk("rel_drop", int'(grant), 0);
    chk("rel_pre", int'(preempt), 0);
    step(4'b1001, 1'b0);
    chk("rel_next", int'(grant), 4'b1000);
    chk("rel_idx", int'(grant_idx), 3);
    step(4'b0011, 1'b0);
    chk("wrap_drop", int'(grant), 0);
    step(4'b0011, 1'b0);
    chk("wrap_next", int'(grant), 4'b0001);
    chk("wrap_idx", int'(grant_idx), 0);

    // Reset mid-grant, then a fresh full budget
    step(4'b0000, 1'b1);
    repeat (6) step(4'b0100, 1'b0);
    step(4'b0100, 1'b1);
    chk("midrst_grant", int'(grant), 0);
    chk("midrst_pre", int'(preempt), 0);
    step(4'b0100, 1'b0);
    chk("fresh_first", int'(grant), 4'b0100);
    repeat (MH - 1) begin
      step(4'b0101, 1'b0);
      chk("fresh_hold", int'(grant), 4'b0100);
    end
    step(4'b0101, 1'b0);
    chk("fresh_cut", int'(grant), 0);
    chk("fresh_pre", int'(preempt), 1);

    // Random traffic
    rv = '0;
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 7) == 0) rv[b] = ~rv[b];
      step(rv, ($urandom_range(0, 249) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
